// File: rtl/nios2_debug_ocimem_ctrl_if.sv
// nios2_debug_ocimem_ctrl_if
//   Single-outstanding request/acknowledge port between the debug OCI
//   memory controller and the on-chip debug memory.
//   master : controller side (drives mem_req/mem_we/mem_addr/mem_wdata)
//   slave  : memory side    (drives mem_rdata/mem_ack)
//   Parameter ADDR_W : word-address width.
interface nios2_debug_ocimem_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/nios2_debug_ocimem_ctrl.sv
// nios2_debug_ocimem_ctrl
//   Sysclk-domain executor of JTAG debugger word reads/writes against the
//   on-chip debug memory. Decodes the debug-slave command strobes, keeps an
//   auto-incrementing word address (MonAReg) and returns results through
//   MonDReg / monitor_ready / monitor_error.
//
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     jdo[37:0]               debug-slave shift data (stable with strobes)
//     take_action_ocimem_a    address command (jdo[37] clr err, jdo[36] read)
//     take_action_ocimem_b    write jdo[34:3] at MonAReg
//     take_no_action_ocimem_a read at MonAReg
//     mem (master modport)    memory request/ack port
//     MonDReg                 monitor data register
//     monitor_ready           1 = idle, MonDReg valid
//     monitor_error           sticky error flag
//
//   Optional feature: define NIOS2_OCIMEM_TIMEOUT_EN to compile in an
//   acknowledge watchdog of TIMEOUT cycles (2..65535).
module nios2_debug_ocimem_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [37:0]               jdo,
  input  logic                      take_action_ocimem_a,
  input  logic                      take_action_ocimem_b,
  input  logic                      take_no_action_ocimem_a,
  nios2_debug_ocimem_ctrl_if.master mem,
  output logic [31:0]               MonDReg,
  output logic                      monitor_ready,
  output logic                      monitor_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

`ifdef NIOS2_OCIMEM_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  logic any_strobe;
  logic unused_jdo;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                      take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[35], jdo[1:0]};

  always_comb begin
    state_d = state_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    ready_d = ready_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef NIOS2_OCIMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Strobe priority: address command, then write, then read-next.
        if (take_action_ocimem_a) begin
          mon_a_d = jdo[ADDR_W+1:2];
          if (jdo[37]) err_d = 1'b0;
          if (jdo[36]) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = jdo[ADDR_W+1:2];
            ready_d = 1'b0;
            state_d = ST_REQ;
          end
        end else if (take_action_ocimem_b) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = mon_a_q;
          wdata_d = jdo[34:3];
          ready_d = 1'b0;
          state_d = ST_REQ;
        end else if (take_no_action_ocimem_a) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = mon_a_q;
          ready_d = 1'b0;
          state_d = ST_REQ;
        end
`ifdef NIOS2_OCIMEM_TIMEOUT_EN
        cnt_d = '0;
`endif
      end

      ST_REQ: begin
        if (any_strobe) err_d = 1'b1;
        // An ack coinciding with watchdog expiry completes normally.
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          if (!we_q) mon_d_d = mem.mem_rdata;
          state_d = ST_DONE;
        end
`ifdef NIOS2_OCIMEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          mon_d_d = 32'hDEAD_BEEF;
          state_d = ST_DONE;
        end else begin
          cnt_d = 16'(cnt_q + 16'd1);
        end
`endif
      end

      ST_DONE: begin
        if (any_strobe) err_d = 1'b1;
        mon_a_d = ADDR_W'(mon_a_q + 1'b1);
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef NIOS2_OCIMEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef NIOS2_OCIMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Testbench for nios2_debug_ocimem_ctrl: table-driven command vectors plus
// hand-written sequences for busy-drop, stray ack, mid-access reset and the
// optional acknowledge watchdog (NIOS2_OCIMEM_TIMEOUT_EN, TIMEOUT=8).
module tb_nios2_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tna_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int checks   = 0;
  int failures = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  nios2_debug_ocimem_ctrl_if #(.ADDR_W(8)) mem ();

  nios2_debug_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .mem                     (mem),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem.mem_req && !req_prev) req_rises++;
    req_prev = mem.mem_req;
  end

  typedef struct {
    logic        a, b, na;
    logic [37:0] jdo;
    int          dly;
    logic [31:0] rdata;
    logic        acc;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mondreg;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [37:0] mk_addr(input logic clr, input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[37] = clr;
    j[36] = rd;
    j[9:2] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Present a strobe for exactly one rising edge; returns at the negedge
  // inside the cycle after the strobe.
  task automatic send(input logic a, input logic b, input logic na, input logic [37:0] j);
    @(negedge clk);
    jdo = j; ta_a = a; ta_b = b; tna_a = na;
    @(negedge clk);
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
  endtask

  // Called in the first REQ cycle; acks in the dly-th REQ cycle and returns
  // at the negedge of the cycle after the ack.
  task automatic complete(input int dly, input logic [31:0] rd);
    for (int k = 1; k < dly; k++) @(negedge clk);
    mem.mem_ack = 1'b1;
    mem.mem_rdata = rd;
    @(negedge clk);
    mem.mem_ack = 1'b0;
  endtask

  initial begin
    int cnt;
    int r0;

    vecs[0] = '{1,0,0, mk_addr(0,1,8'h10), 1, 32'h1234_5678, 1, 0, 8'h10, 32'h0, 32'h1234_5678};
    vecs[1] = '{0,0,1, 38'h0,              2, 32'hA5A5_0001, 1, 0, 8'h11, 32'h0, 32'hA5A5_0001};
    vecs[2] = '{1,0,0, mk_addr(0,0,8'hFF), 1, 32'h0,         0, 0, 8'h00, 32'h0, 32'hA5A5_0001};
    vecs[3] = '{0,1,0, mk_data(32'hCAFE_F00D), 3, 32'h0,     1, 1, 8'hFF, 32'hCAFE_F00D, 32'hA5A5_0001};
    vecs[4] = '{0,0,1, 38'h0,              1, 32'h0BAD_F00D, 1, 0, 8'h00, 32'h0, 32'h0BAD_F00D};
    vecs[5] = '{1,1,0, mk_addr(0,0,8'h40), 1, 32'h0,         0, 0, 8'h00, 32'h0, 32'h0BAD_F00D};
    vecs[6] = '{0,0,1, 38'h0,              1, 32'h1111_2222, 1, 0, 8'h40, 32'h0, 32'h1111_2222};
    vecs[7] = '{1,1,1, mk_addr(0,1,8'h80), 2, 32'h7777_8888, 1, 0, 8'h80, 32'h0, 32'h7777_8888};

    reset_n = 1'b0;
    jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", monitor_ready, 1'b1);
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_error", monitor_error, 1'b0);
    chk("rst_req", mem.mem_req, 1'b0);
    chk("rst_addr", mem.mem_addr, 8'h00);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].na, vecs[i].jdo);
      if (vecs[i].acc) begin
        chk($sformatf("v%0d_req", i), mem.mem_req, 1'b1);
        chk($sformatf("v%0d_busy", i), monitor_ready, 1'b0);
        chk($sformatf("v%0d_we", i), mem.mem_we, vecs[i].we);
        chk($sformatf("v%0d_addr", i), mem.mem_addr, vecs[i].addr);
        if (vecs[i].we) chk($sformatf("v%0d_wdata", i), mem.mem_wdata, vecs[i].wdata);
        complete(vecs[i].dly, vecs[i].rdata);
        chk($sformatf("v%0d_req_drop", i), mem.mem_req, 1'b0);
        chk($sformatf("v%0d_mondreg", i), MonDReg, vecs[i].mondreg);
        chk($sformatf("v%0d_not_ready_yet", i), monitor_ready, 1'b0);
        @(negedge clk);
        chk($sformatf("v%0d_ready", i), monitor_ready, 1'b1);
      end else begin
        chk($sformatf("v%0d_noreq", i), mem.mem_req, 1'b0);
        chk($sformatf("v%0d_ready", i), monitor_ready, 1'b1);
        chk($sformatf("v%0d_mondreg", i), MonDReg, vecs[i].mondreg);
      end
      chk($sformatf("v%0d_err", i), monitor_error, 1'b0);
    end

    // Read-next strobe while busy: dropped, error set, single request.
    r0 = req_rises;
    send(0, 0, 1, 38'h0);
    chk("busy_addr", mem.mem_addr, 8'h81);
    @(negedge clk);
    tna_a = 1'b1;
    @(negedge clk);
    tna_a = 1'b0;
    complete(3, 32'h5555_AAAA);
    chk("busy_err", monitor_error, 1'b1);
    chk("busy_mondreg", MonDReg, 32'h5555_AAAA);
    repeat (4) @(negedge clk);
    chk("busy_one_req", req_rises - r0, 1);
    send(0, 0, 1, 38'h0);
    chk("busy_next_addr", mem.mem_addr, 8'h82);
    complete(1, 32'h0000_0082);
    @(negedge clk);
    chk("err_sticky", monitor_error, 1'b1);
    send(1, 0, 0, mk_addr(1, 0, 8'h20));
    chk("err_clear", monitor_error, 1'b0);
    chk("addr_only_ready", monitor_ready, 1'b1);

    // Stray ack in IDLE is ignored.
    @(negedge clk);
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem.mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_mondreg", MonDReg, 32'h0000_0082);
    chk("stray_ready", monitor_ready, 1'b1);
    send(0, 0, 1, 38'h0);
    chk("stray_addr", mem.mem_addr, 8'h20);
    complete(1, 32'h2020_2020);
    @(negedge clk);

    // Reset mid-access aborts immediately; MonAReg returns to 0.
    send(0, 0, 1, 38'h0);
    chk("midrst_addr", mem.mem_addr, 8'h21);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_req", mem.mem_req, 1'b0);
    chk("midrst_ready", monitor_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_mondreg", MonDReg, 32'h0);
    send(0, 0, 1, 38'h0);
    chk("midrst_next_addr", mem.mem_addr, 8'h00);
    complete(1, 32'hABCD_0000);
    @(negedge clk);

`ifdef NIOS2_OCIMEM_TIMEOUT_EN
    // Ack in the expiry cycle wins.
    send(0, 0, 1, 38'h0);
    complete(8, 32'h600D_600D);
    chk("to_edge_mondreg", MonDReg, 32'h600D_600D);
    chk("to_edge_err", monitor_error, 1'b0);
    @(negedge clk);
    chk("to_edge_ready", monitor_ready, 1'b1);
    // No ack: watchdog fires after 8 request cycles.
    send(0, 0, 1, 38'h0);
    chk("to_addr", mem.mem_addr, 8'h02);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!mem.mem_req) break;
      cnt++;
      @(negedge clk);
    end
    chk("to_req_cycles", cnt, 8);
    chk("to_mondreg", MonDReg, 32'hDEAD_BEEF);
    chk("to_err", monitor_error, 1'b1);
    @(negedge clk);
    chk("to_ready", monitor_ready, 1'b1);
`else
    // Without the watchdog the request waits indefinitely.
    send(0, 0, 1, 38'h0);
    repeat (100) @(negedge clk);
    cnt = 0;
    chk("wait_req", mem.mem_req, 1'b1);
    chk("wait_busy", monitor_ready, 1'b0);
    complete(1, 32'h1357_9BDF);
    chk("wait_mondreg", MonDReg, 32'h1357_9BDF);
    @(negedge clk);
    chk("wait_ready", monitor_ready, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios2_debug_ocimem_ctrl.md
# nios2_debug_ocimem_ctrl

Sysclk-domain consumer of the decoded debug-slave command strobes and `jdo` shift data: it executes the JTAG debugger's word reads and writes against the on-chip debug memory and returns the results to the debug-slave TCK logic.
- The TCK logic reads back `MonDReg`, `monitor_ready` and `monitor_error` on its next capture.
- The block holds a word address register with auto-increment, so the host can burst through memory.
- A single-outstanding request/acknowledge handshake drives the memory port.

## Interface
Parameters:
- ADDR_W, 8: debug memory word-address width (256 words).
- TIMEOUT, 64: acknowledge watchdog limit in cycles, used only when the watchdog is compiled in; legal range 2..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  debug-slave shift register contents, stable while any strobe is high.
- take_action_ocimem_a  in  1  one-cycle strobe: address command.
- take_action_ocimem_b  in  1  one-cycle strobe: write-data command.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read-next command.
- mem_req  out  1  memory request; held until `mem_ack`.
- mem_we  out  1  1 = write, 0 = read; valid with `mem_req`.
- mem_addr  out  ADDR_W  word address; valid with `mem_req`.
- mem_wdata  out  32  write data; valid with `mem_req`.
- mem_rdata  in  32  read data; valid in the `mem_ack` cycle.
- mem_ack  in  1  one-cycle completion.
- MonDReg  out  32  monitor data register.
- monitor_ready  out  1  1 = idle, `MonDReg` valid.
- monitor_error  out  1  sticky error flag.

## Operation
Command decode (priority when strobes coincide: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`):
- `take_action_ocimem_a`:
  - MonAReg <= jdo[ADDR_W+1:2].
  - If jdo[37]: clear `monitor_error`.
  - If jdo[36]: start a read at the new address.
- `take_action_ocimem_b`: start a write of jdo[34:3] to MonAReg.
- `take_no_action_ocimem_a`: start a read at MonAReg.

State machine IDLE, REQ, DONE:
- IDLE -> REQ: a command that starts an access.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - `monitor_ready` goes 0.
- REQ -> DONE: on `mem_ack`.
  - Read: MonDReg <= mem_rdata.
  - Write: MonDReg unchanged.
- DONE -> IDLE: unconditional after one cycle.
  - MonAReg <= MonAReg + 1, wrapping modulo 2^ADDR_W (all-ones -> 0).
  - `monitor_ready` goes 1.
- A strobe arriving outside IDLE is dropped, MonAReg is unchanged, and `monitor_error` is set. This includes address-only commands.
- Address-only command (jdo[36]=0) in IDLE: no memory access, `monitor_ready` stays 1, no increment.

Reset values:
- `mem_req`, `mem_we`, `monitor_error` = 0.
- `mem_addr`, `mem_wdata`, `MonDReg`, MonAReg = 0.
- `monitor_ready` = 1; state = IDLE.

Reset asserted mid-access aborts immediately with no increment. `mem_ack` outside REQ is ignored.

## Timing
- Strobe in cycle N -> `mem_req`=1 and `monitor_ready`=0 from N+1.
- `mem_ack` in cycle M -> `mem_req`=0 from M+1, with `MonDReg` updated at M+1.
- `monitor_ready`=1 and MonAReg incremented from M+2.
- Minimum access: strobe at N, ack at N+1 -> ready at N+3.
- `mem_ack` is never sampled in the same cycle as the request launch.

## Configuration
- `NIOS2_OCIMEM_TIMEOUT_EN` defined:
  - A counter runs in REQ.
  - If `mem_ack` is absent for TIMEOUT cycles:
    - `mem_req` drops.
    - `monitor_error` is set.
    - `MonDReg` <= 32'hDEADBEEF.
    - State -> DONE, so ready and the increment occur as normal.
  - `mem_ack` in the same cycle the count expires wins: normal completion.
- Undefined: no counter. REQ waits indefinitely for `mem_ack`.

## Test plan
- Reset release -> `monitor_ready`=1, `MonDReg`=0, `monitor_error`=0, `mem_req`=0.
- `take_action_ocimem_a` with addr 0x10 and jdo[36]=1, memory acks in 1 cycle with 0x12345678:
  - `mem_addr`=0x10, `mem_we`=0.
  - `MonDReg`=0x12345678 at ack+1; ready at ack+2.
  - MonAReg=0x11.
- Address 0xFF, then `take_action_ocimem_b` with data 0xCAFEF00D:
  - `mem_we`=1, `mem_wdata`=0xCAFEF00D, `mem_addr`=0xFF.
  - After completion MonAReg=0x00 (wrap).
- `take_no_action_ocimem_a` while in REQ (ack delayed 5 cycles):
  - Second command dropped, `monitor_error`=1, only one `mem_req` pulse train.
  - Subsequent `take_action_ocimem_a` with jdo[37]=1 clears the error.
- `take_action_ocimem_a` and `take_action_ocimem_b` in the same cycle -> address command taken, no write issued.
- `NIOS2_OCIMEM_TIMEOUT_EN` with TIMEOUT=8, no ack:
  - `mem_req` drops after 8 cycles.
  - `MonDReg`=0xDEADBEEF, `monitor_error`=1, ready returns.
